// File: rtl/pattern_hit_display.sv
// pattern_hit_display: counts detector hits in BCD, stretches each hit
// onto an LED and scans the count onto a 4-digit 7-segment display.
module pattern_hit_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int STRETCH_CYC = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_detect,
  input  logic        i_clear,
  output logic [15:0] o_count,
  output logic        o_hit_led,
  output logic [6:0]  o_seg,
  output logic [3:0]  o_an,
  output logic        o_dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(STRETCH_CYC + 1);
  localparam logic [PW-1:0] PRE_TC = PW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] ST_LD = SW'(STRETCH_CYC);

  logic          det_d;
  logic          hit;
  logic [15:0]   inc;
  logic          carry;
  logic [SW-1:0] st_cnt;
  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic [3:0]    blank;
  logic [3:0]    dig;
  logic          dig_blank;
  logic [6:0]    dec;

  assign hit = i_detect & ~det_d;

  // Delayed copy of the match level for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) det_d <= 1'b0;
    else      det_d <= i_detect;
  end

  // BCD increment with ripple carry across all four digits.
  always_comb begin
    inc   = o_count;
    carry = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (carry) begin
        if (o_count[4*k +: 4] == 4'd9) begin
          inc[4*k +: 4] = 4'd0;
        end else begin
          inc[4*k +: 4] = o_count[4*k +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Hit counter; clear wins over a coincident hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         o_count <= '0;
    else if (i_clear) o_count <= '0;
    else if (hit)     o_count <= inc;
  end

  // LED stretch counter, reloaded on every hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              st_cnt <= '0;
    else if (i_clear)      st_cnt <= '0;
    else if (hit)          st_cnt <= ST_LD;
    else if (st_cnt != '0) st_cnt <= st_cnt - 1'b1;
  end

  // Registered LED from the stretch counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_hit_led <= 1'b0;
    else      o_hit_led <= (st_cnt != '0);
  end

  // Refresh prescaler and digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
      idx <= 2'd0;
    end else if (pre == PRE_TC) begin
      pre <= '0;
      idx <= idx + 2'd1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Leading-zero blanking and selected digit decode.
  always_comb begin
    blank[3] = (o_count[15:12] == 4'd0);
    blank[2] = blank[3] && (o_count[11:8] == 4'd0);
    blank[1] = blank[2] && (o_count[7:4] == 4'd0);
    blank[0] = 1'b0;
    dig       = o_count[3:0];
    dig_blank = 1'b0;
    unique case (idx)
      2'd0: begin dig = o_count[3:0];   dig_blank = blank[0]; end
      2'd1: begin dig = o_count[7:4];   dig_blank = blank[1]; end
      2'd2: begin dig = o_count[11:8];  dig_blank = blank[2]; end
      2'd3: begin dig = o_count[15:12]; dig_blank = blank[3]; end
    endcase
    dec = 7'b1111111;
    case (dig)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b1111111;
    endcase
  end

  // Display output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_an  <= 4'b1111;
      o_seg <= 7'b1111111;
      o_dp  <= 1'b1;
    end else begin
      o_an  <= dig_blank ? 4'b1111 : ~(4'b0001 << idx);
      o_seg <= dig_blank ? 7'b1111111 : dec;
      o_dp  <= ~((idx == 2'd0) && o_hit_led);
    end
  end

endmodule

// File: tb/tb_pattern_hit_display.sv
// tb_pattern_hit_display: directed bench for pattern_hit_display
// with a short refresh divider and stretch length.
module tb_pattern_hit_display;

  logic        clk;
  logic        rst;
  logic        i_detect;
  logic        i_clear;
  logic [15:0] o_count;
  logic        o_hit_led;
  logic [6:0]  o_seg;
  logic [3:0]  o_an;
  logic        o_dp;

  int total;
  int bad;
  int ncyc;

  logic [19:0] det_pat;
  logic [19:0] led_pat;

  pattern_hit_display #(
    .REFRESH_DIV(4),
    .STRETCH_CYC(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_detect(i_detect),
    .i_clear(i_clear),
    .o_count(o_count),
    .o_hit_led(o_hit_led),
    .o_seg(o_seg),
    .o_an(o_an),
    .o_dp(o_dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic pulse();
    i_detect = 1'b1;
    tick();
    i_detect = 1'b0;
    tick();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  task automatic scan_check(input string tag, input logic [3:0] vis,
                            input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0);
    int n0, n1, n2, n3, nerr;
    n0 = 0; n1 = 0; n2 = 0; n3 = 0; nerr = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      case (o_an)
        4'b1110: begin n0++; if (o_seg !== s0) nerr++; end
        4'b1101: begin n1++; if (o_seg !== s1) nerr++; end
        4'b1011: begin n2++; if (o_seg !== s2) nerr++; end
        4'b0111: begin n3++; if (o_seg !== s3) nerr++; end
        4'b1111: if (o_seg !== 7'b1111111) nerr++;
        default: nerr++;
      endcase
    end
    chk({tag, "_slot0"}, n0, vis[0] ? 4 : 0);
    chk({tag, "_slot1"}, n1, vis[1] ? 4 : 0);
    chk({tag, "_slot2"}, n2, vis[2] ? 4 : 0);
    chk({tag, "_slot3"}, n3, vis[3] ? 4 : 0);
    chk({tag, "_segerr"}, nerr, 0);
  endtask

  initial begin
    int n_vis, n_blk, n_err, n_led, n_dp;
    logic led_prev;
    logic dp_exp;
    bit found;
    total = 0;
    bad = 0;
    ncyc = 0;
    det_pat = 20'b00000010001111111111;
    led_pat = 20'b01111100000000111110;
    rst = 1'b0;
    i_detect = 1'b0;
    i_clear = 1'b0;

    #12;
    chk("rst_count", o_count, 16'h0000);
    chk("rst_led", o_hit_led, 1'b0);
    chk("rst_seg", o_seg, 7'b1111111);
    chk("rst_an", o_an, 4'b1111);
    chk("rst_dp", o_dp, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    ncyc = 0;

    n_vis = 0; n_blk = 0; n_err = 0; n_led = 0; n_dp = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_an == 4'b1110) begin
        n_vis++;
        if (o_seg !== 7'b1000000) n_err++;
      end else if (o_an == 4'b1111) begin
        n_blk++;
        if (o_seg !== 7'b1111111) n_err++;
      end else begin
        n_err++;
      end
      if (o_hit_led) n_led++;
      if (!o_dp) n_dp++;
    end
    chk("idle_count", o_count, 16'h0000);
    chk("idle_vis", n_vis, 8);
    chk("idle_blank", n_blk, 12);
    chk("idle_segerr", n_err, 0);
    chk("idle_led", n_led, 0);
    chk("idle_dp", n_dp, 0);

    n_dp = 0;
    for (int j = 0; j < 20; j++) begin
      i_detect = det_pat[j];
      tick();
      led_prev = (j == 0) ? 1'b0 : led_pat[j-1];
      dp_exp = !((((ncyc - 1) / 4) % 4 == 0) && led_prev);
      chk($sformatf("str_led%0d", j), o_hit_led, led_pat[j]);
      chk($sformatf("str_dp%0d", j), o_dp, dp_exp);
      if (!o_dp) n_dp++;
      if (j == 0) chk("str_first", o_count, 16'h0001);
    end
    i_detect = 1'b0;
    chk("str_count", o_count, 16'h0002);
    chk("str_dp_seen", n_dp > 0, 1'b1);

    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    chk("clr_count", o_count, 16'h0000);
    pulses(9);
    chk("cnt_0009", o_count, 16'h0009);
    pulses(1);
    chk("cnt_0010", o_count, 16'h0010);
    pulses(89);
    chk("cnt_0099", o_count, 16'h0099);
    tick();
    scan_check("s99", 4'b0011, 7'h7f, 7'h7f, 7'b0010000, 7'b0010000);
    pulses(1);
    chk("cnt_0100", o_count, 16'h0100);
    tick();
    scan_check("s100", 4'b0111, 7'h7f, 7'b1111001, 7'b1000000,
               7'b1000000);

    pulses(9899);
    chk("cnt_9999", o_count, 16'h9999);
    tick();
    scan_check("s9999", 4'b1111, 7'b0010000, 7'b0010000, 7'b0010000,
               7'b0010000);
    pulses(1);
    chk("cnt_wrap", o_count, 16'h0000);
    tick();
    scan_check("swrap", 4'b0001, 7'h7f, 7'h7f, 7'h7f, 7'b1000000);

    pulses(42);
    chk("cnt_0042", o_count, 16'h0042);
    for (int i = 0; i < 8; i++) tick();
    chk("pre_clr_led", o_hit_led, 1'b0);
    i_detect = 1'b1;
    i_clear = 1'b1;
    tick();
    chk("clrhit_count", o_count, 16'h0000);
    i_clear = 1'b0;
    n_led = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_hit_led) n_led++;
    end
    chk("clrhit_hold", o_count, 16'h0000);
    chk("clrhit_led", n_led, 0);
    i_detect = 1'b0;
    tick();

    pulses(17);
    chk("cnt_0017", o_count, 16'h0017);
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      tick();
      if (o_an != 4'b1111) found = 1'b1;
    end
    chk("mid_lit", found, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_an", o_an, 4'b1111);
    chk("mid_seg", o_seg, 7'b1111111);
    chk("mid_count", o_count, 16'h0000);
    chk("mid_led", o_hit_led, 1'b0);
    chk("mid_dp", o_dp, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    ncyc = 0;
    pulses(1);
    chk("post_rst", o_count, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
